dt_enemy_fz_array: RTL and testbench

DT_ENEMY_FZ_ARRAY -- requirements
Module: dt_enemy_fz_array

---
 rtl/dt_fz_pkg.sv | 34 +++
 rtl/dt_fz_chan.sv | 139 +++++++++++++
 rtl/dt_enemy_fz_array.sv | 68 ++++++
 tb/tb_dt_enemy_fz_array.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dt_fz_pkg.sv
// Shared types and constants for the enemy freeze array.
// Holds the channel state enum, coordinate widths and parameter defaults.
package dt_fz_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FROZEN = 2'd1,
    COOL   = 2'd2
  } fz_state_t;

  localparam int X_W = 10;
  localparam int Y_W = 9;

  localparam int N_ENEMY_DEF    = 4;
  localparam int HIT_W_DEF      = 62;
  localparam int FOOT_OFS_X_DEF = 24;
  localparam int FOOT_OFS_Y_DEF = 41;
  localparam int Y_TOL_DEF      = 2;
  localparam int TICK_DIV_DEF   = 6000000;
  localparam int FZ_TICKS_DEF   = 15;
  localparam int COOL_TICKS_DEF = 4;

  function automatic int cnt_width(
    input int fz,
    input int cool
  );
    int m;
    m = fz;
    if (cool > m) m = cool;
    if (m < 2) m = 2;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/dt_fz_chan.sv
// One enemy channel: stomp-band hit compare, IDLE/FROZEN/COOL FSM, tick counter.
// Ports: clk, rst_n (sync, active-low), tick, player/enemy coords, alive;
// outputs frozen, fz_start, thaw. FZ_REFREEZE_EN lets a hit restart a freeze.
module dt_fz_chan
  import dt_fz_pkg::*;
#(
  parameter int HIT_W      = HIT_W_DEF,
  parameter int FOOT_OFS_X = FOOT_OFS_X_DEF,
  parameter int FOOT_OFS_Y = FOOT_OFS_Y_DEF,
  parameter int Y_TOL      = Y_TOL_DEF,
  parameter int FZ_TICKS   = FZ_TICKS_DEF,
  parameter int COOL_TICKS = COOL_TICKS_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           tick,
  input  logic [X_W-1:0] x_blue,
  input  logic [Y_W-1:0] y_blue,
  input  logic [X_W-1:0] x_slim,
  input  logic [Y_W-1:0] y_slim,
  input  logic           alive,
  output logic           frozen,
  output logic           fz_start,
  output logic           thaw
);

  localparam int XE    = X_W + 1;
  localparam int YE    = Y_W + 1;
  localparam int CNT_W = cnt_width(FZ_TICKS, COOL_TICKS);

  localparam logic [CNT_W-1:0] FZ_LAST =
    CNT_W'(FZ_TICKS - 1);
  localparam logic [CNT_W-1:0] CL_LAST =
    CNT_W'((COOL_TICKS > 0) ? COOL_TICKS - 1 : 0);
  localparam fz_state_t THAW_TO =
    (COOL_TICKS > 0) ? COOL : IDLE;

  // One extra bit on every sum so nothing wraps at the screen edge.
  logic [XE-1:0] foot_x;
  logic [XE-1:0] ex_lo;
  logic [XE-1:0] ex_hi;
  logic [YE-1:0] foot_y;
  logic [YE-1:0] foot_y_tol;
  logic [YE-1:0] ey_lo;
  logic [YE-1:0] ey_tol;
  logic          hit;

  assign foot_x     = {1'b0, x_blue} + XE'(FOOT_OFS_X);
  assign ex_lo      = {1'b0, x_slim};
  assign ex_hi      = {1'b0, x_slim} + XE'(HIT_W);
  assign foot_y     = {1'b0, y_blue} + YE'(FOOT_OFS_Y);
  assign foot_y_tol = foot_y + YE'(Y_TOL);
  assign ey_lo      = {1'b0, y_slim};
  assign ey_tol     = {1'b0, y_slim} + YE'(Y_TOL);

  assign hit = alive
             && (ex_lo < foot_x)
             && (foot_x < ex_hi)
             && (foot_y_tol > ey_lo)
             && (foot_y < ey_tol);

  fz_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fz_start_q, fz_start_d;
  logic             thaw_q, thaw_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      fz_start_q <= 1'b0;
      thaw_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      fz_start_q <= fz_start_d;
      thaw_q     <= thaw_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    fz_start_d = 1'b0;
    thaw_d     = 1'b0;
    if (!alive) begin
      // Despawn overrides everything; a live freeze still reports its end.
      state_d = IDLE;
      cnt_d   = '0;
      thaw_d  = (state_q == FROZEN);
    end else begin
      unique case (state_q)
        IDLE: begin
          if (hit) begin
            state_d    = FROZEN;
            cnt_d      = '0;
            fz_start_d = 1'b1;
          end
        end
        FROZEN: begin
`ifdef FZ_REFREEZE_EN
          if (hit) begin
            cnt_d      = '0;
            fz_start_d = 1'b1;
          end else
`endif
          if (tick) begin
            if (cnt_q == FZ_LAST) begin
              state_d = THAW_TO;
              cnt_d   = '0;
              thaw_d  = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        COOL: begin
          if (tick) begin
            if (cnt_q == CL_LAST) begin
              state_d = IDLE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign frozen   = (state_q == FROZEN);
  assign fz_start = fz_start_q;
  assign thaw     = thaw_q;

endmodule

// File: rtl/dt_enemy_fz_array.sv
// Array of N_ENEMY freeze channels sharing one freeze-tick prescaler.
// Ports: clk, rst_n (sync, active-low), player/enemy coords, alive -> frozen,
// fz_start, thaw, any_frozen. Macro FZ_REFREEZE_EN: hit while frozen restarts.
module dt_enemy_fz_array
  import dt_fz_pkg::*;
#(
  parameter int N_ENEMY    = N_ENEMY_DEF,
  parameter int HIT_W      = HIT_W_DEF,
  parameter int FOOT_OFS_X = FOOT_OFS_X_DEF,
  parameter int FOOT_OFS_Y = FOOT_OFS_Y_DEF,
  parameter int Y_TOL      = Y_TOL_DEF,
  parameter int TICK_DIV   = TICK_DIV_DEF,
  parameter int FZ_TICKS   = FZ_TICKS_DEF,
  parameter int COOL_TICKS = COOL_TICKS_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [X_W-1:0]           x_blue,
  input  logic [Y_W-1:0]           y_blue,
  input  logic [X_W*N_ENEMY-1:0]   x_slim,
  input  logic [Y_W*N_ENEMY-1:0]   y_slim,
  input  logic [N_ENEMY-1:0]       alive,
  output logic [N_ENEMY-1:0]       frozen,
  output logic [N_ENEMY-1:0]       fz_start,
  output logic [N_ENEMY-1:0]       thaw,
  output logic                     any_frozen
);

  localparam int PS_W = $clog2(TICK_DIV);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);

  logic [PS_W-1:0] ps_q, ps_d;
  logic            tick;

  assign tick = (ps_q == PS_LAST);
  assign ps_d = tick ? '0 : ps_q + PS_W'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) ps_q <= '0;
    else        ps_q <= ps_d;
  end

  for (genvar i = 0; i < N_ENEMY; i++) begin : g_chan
    dt_fz_chan #(
      .HIT_W      (HIT_W),
      .FOOT_OFS_X (FOOT_OFS_X),
      .FOOT_OFS_Y (FOOT_OFS_Y),
      .Y_TOL      (Y_TOL),
      .FZ_TICKS   (FZ_TICKS),
      .COOL_TICKS (COOL_TICKS)
    ) u_chan (
      .clk      (clk),
      .rst_n    (rst_n),
      .tick     (tick),
      .x_blue   (x_blue),
      .y_blue   (y_blue),
      .x_slim   (x_slim[X_W*i +: X_W]),
      .y_slim   (y_slim[Y_W*i +: Y_W]),
      .alive    (alive[i]),
      .frozen   (frozen[i]),
      .fz_start (fz_start[i]),
      .thaw     (thaw[i])
    );
  end

  assign any_frozen = |frozen;

endmodule

// File: tb/tb_dt_enemy_fz_array.sv
// Directed bench for dt_enemy_fz_array (N=4, TICK_DIV=4, FZ=3, COOL=2).
// Expectations follow FZ_REFREEZE_EN when it is defined.
module tb_dt_enemy_fz_array;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  x_blue = 10'd100;
  logic [8:0]  y_blue = 9'd59;
  logic [39:0] x_slim = '0;
  logic [35:0] y_slim = '0;
  logic [3:0]  alive = 4'hf;
  logic [3:0]  frozen, fz_start, thaw;
  logic        any_frozen;

  logic [9:0]  xb2 = 10'd100;
  logic [8:0]  yb2 = 9'd1;
  logic [9:0]  xs2 = 10'd110;
  logic [8:0]  ys2 = 9'd0;
  logic [0:0]  al2 = 1'b1;
  logic [0:0]  fr2, fs2, th2;
  logic        af2;

  always #5 clk = ~clk;

  dt_enemy_fz_array #(
    .N_ENEMY(4), .TICK_DIV(4), .FZ_TICKS(3), .COOL_TICKS(2)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .x_blue(x_blue), .y_blue(y_blue),
    .x_slim(x_slim), .y_slim(y_slim), .alive(alive),
    .frozen(frozen), .fz_start(fz_start), .thaw(thaw),
    .any_frozen(any_frozen)
  );

  dt_enemy_fz_array #(
    .N_ENEMY(1), .FOOT_OFS_Y(0), .TICK_DIV(4),
    .FZ_TICKS(3), .COOL_TICKS(2)
  ) dut_y0 (
    .clk(clk), .rst_n(rst_n),
    .x_blue(xb2), .y_blue(yb2),
    .x_slim(xs2), .y_slim(ys2), .alive(al2),
    .frozen(fr2), .fz_start(fs2), .thaw(th2),
    .any_frozen(af2)
  );

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  bit fr_h[0:63];
  bit fs_h[0:63];
  bit th_h[0:63];

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic adv(input int ch);
    @(posedge clk);
    #1;
    cyc++;
    fr_h[cyc] = frozen[ch];
    fs_h[cyc] = fz_start[ch];
    th_h[cyc] = thaw[ch];
  endtask

  function automatic int cnt_hist(input int kind);
    int n = 0;
    for (int c = 1; c <= cyc; c++) begin
      if (kind == 0 && fr_h[c]) n++;
      if (kind == 1 && fs_h[c]) n++;
      if (kind == 2 && th_h[c]) n++;
    end
    return n;
  endfunction

  function automatic int first_th();
    for (int c = 1; c <= cyc; c++)
      if (th_h[c]) return c;
    return 0;
  endfunction

  task automatic place(
    input int i,
    input int x,
    input int y
  );
    x_slim[10*i +: 10] = 10'(x);
    y_slim[9*i +: 9]   = 9'(y);
  endtask

  task automatic rst();
    rst_n  = 1'b0;
    x_blue = 10'd100;
    y_blue = 9'd59;
    alive  = 4'hf;
    for (int i = 0; i < 4; i++) place(i, 500, 300);
    adv(0);
    adv(0);
    chk("rst_frozen", frozen, 0);
    chk("rst_fzs", fz_start, 0);
    chk("rst_thaw", thaw, 0);
    chk("rst_any", any_frozen, 0);
    rst_n = 1'b1;
    cyc = 0;
  endtask

  task automatic try_hit(
    input string tag,
    input int xb, input int yb,
    input int xs, input int ys,
    input int exp
  );
    rst();
    x_blue = 10'(xb);
    y_blue = 9'(yb);
    place(0, xs, ys);
    adv(0);
    adv(0);
    chk(tag, frozen[0], exp);
  endtask

  initial begin
    rst();

    // single stomp, then cooldown
    place(0, 110, 100);
    adv(0);
    chk("a_frozen", frozen, 4'b0001);
    chk("a_fzs", fz_start, 4'b0001);
    chk("a_any", any_frozen, 1);
    chk("y0_out", {fr2, fs2, th2, af2}, 4'b1101);
    place(0, 500, 300);
    repeat (21) adv(0);
    chk("a_fr_len", cnt_hist(0), 11);
    chk("a_fzs_n", cnt_hist(1), 1);
    chk("a_thaw_at", first_th(), 12);
    chk("a_thaw_n", cnt_hist(2), 1);

    // hit held throughout
    rst();
    place(0, 110, 100);
    repeat (22) adv(0);
`ifdef FZ_REFREEZE_EN
    chk("b_fr_len", cnt_hist(0), 22);
    chk("b_fzs_n", cnt_hist(1), 22);
    chk("b_thaw_n", cnt_hist(2), 0);
`else
    chk("b_fr_len", cnt_hist(0), 13);
    chk("b_fzs_n", cnt_hist(1), 2);
    chk("b_thaw_at", first_th(), 12);
    chk("b_cool", fr_h[20], 0);
    chk("b_refrz", fr_h[21], 1);
`endif

    // hitbox boundaries
    try_hit("x_lo_edge", 86, 59, 110, 100, 0);
    try_hit("x_hi_edge", 148, 59, 110, 100, 0);
    try_hit("x_lo_in", 87, 59, 110, 100, 1);
    try_hit("x_hi_in", 147, 59, 110, 100, 1);
    try_hit("x_wide", 981, 59, 1000, 100, 1);
    try_hit("y_wide", 100, 471, 110, 511, 1);
    try_hit("y_lo_out", 100, 59, 110, 98, 0);
    try_hit("y_hi_out", 100, 59, 110, 102, 0);
    try_hit("y_hi_in", 100, 59, 110, 101, 1);

    // simultaneous freeze, then despawn of channel 2
    rst();
    place(0, 110, 100);
    place(1, 110, 100);
    place(2, 110, 100);
    adv(2);
    chk("d_frozen", frozen, 4'b0111);
    chk("d_fzs", fz_start, 4'b0111);
    place(0, 500, 300);
    place(1, 500, 300);
    alive = 4'b1011;
    adv(2);
    chk("d_kill_fr", frozen, 4'b0011);
    chk("d_kill_th", thaw, 4'b0100);
    chk("d_kill_fs", fz_start, 0);
    adv(2);
    chk("d_dead_fr", frozen, 4'b0011);
    chk("d_dead_fs", fz_start, 0);
    chk("d_dead_th", thaw, 0);

    // second stomp mid-freeze
    rst();
    place(0, 110, 100);
    adv(0);
    place(0, 500, 300);
    repeat (5) adv(0);
    place(0, 110, 100);
    adv(0);
    place(0, 500, 300);
    repeat (15) adv(0);
`ifdef FZ_REFREEZE_EN
    chk("e_fzs_n", cnt_hist(1), 2);
    chk("e_fzs_at", fs_h[7], 1);
    chk("e_thaw_at", first_th(), 16);
    chk("e_fr_len", cnt_hist(0), 15);
`else
    chk("e_fzs_n", cnt_hist(1), 1);
    chk("e_thaw_at", first_th(), 12);
    chk("e_fr_len", cnt_hist(0), 11);
`endif

    // reset mid-freeze
    rst();
    place(1, 110, 100);
    adv(1);
    chk("f_frozen", frozen, 4'b0010);
    place(1, 500, 300);
    repeat (4) adv(1);
    chk("f_mid", frozen[1], 1);
    rst_n = 1'b0;
    place(1, 110, 100);
    adv(1);
    chk("f_rst_fr", frozen, 0);
    chk("f_rst_th", thaw, 0);
    chk("f_rst_fs", fz_start, 0);
    chk("f_rst_any", any_frozen, 0);
    rst_n = 1'b1;
    cyc = 0;
    adv(1);
    chk("f_refrz", frozen, 4'b0010);
    place(1, 500, 300);
    repeat (13) adv(1);
    chk("f_thaw_at", first_th(), 12);
    chk("f_fr_len", cnt_hist(0), 11);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
